iob_ethmac_init_seq: RTL

//  Hardware bring-up sequencer upstream of the iob_ethmac native slave port. On start it runs a

---
 rtl/iob_ethmac_seq_pkg.sv | 60 ++++++
 rtl/iob_ethmac_seq_rom.sv | 48 ++++
 rtl/iob_ethmac_init_seq.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/iob_ethmac_seq_pkg.sv
// ----------------------------------------------------------------------------
// iob_ethmac_seq_pkg
// Shared definitions for the ethmac bring-up sequencer:
//   - opcodes of the command program
//   - ethmac register offsets used by the default program
//   - command word layout {op, addr, data} and a helper that packs it
//   - FSM state encoding
// ----------------------------------------------------------------------------
package iob_ethmac_seq_pkg;

   // Command word field widths. The ethmac register map is 12-bit byte
   // addressed and its bus is 32 bits wide.
   localparam int OP_W       = 3;
   localparam int CMD_ADDR_W = 12;
   localparam int CMD_DATA_W = 32;
   localparam int CMD_W      = OP_W + CMD_ADDR_W + CMD_DATA_W;

   // Opcodes. Codes 5..7 are illegal and stop the program with an error.
   localparam logic [OP_W-1:0] OP_WR   = 3'd0;
   localparam logic [OP_W-1:0] OP_RD   = 3'd1;
   localparam logic [OP_W-1:0] OP_POLL = 3'd2;
   localparam logic [OP_W-1:0] OP_WIRQ = 3'd3;
   localparam logic [OP_W-1:0] OP_END  = 3'd4;

   // ethmac register offsets
   localparam logic [CMD_ADDR_W-1:0] REG_MODER      = 12'h000;
   localparam logic [CMD_ADDR_W-1:0] REG_INT_SOURCE = 12'h004;
   localparam logic [CMD_ADDR_W-1:0] REG_INT_MASK   = 12'h008;
   localparam logic [CMD_ADDR_W-1:0] REG_TX_BD0     = 12'h400;
   localparam logic [CMD_ADDR_W-1:0] REG_RX_BD0     = 12'h600;

   // One ROM entry. For POLL the data field is the bit mask to wait on.
   typedef struct packed {
      logic [OP_W-1:0]       op;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] data;
   } cmd_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_ISSUE,
      ST_WAIT_RSP,
      ST_CHECK,
      ST_WAIT_IRQ,
      ST_DONE,
      ST_ERR
   } state_e;

   function automatic cmd_t pack_cmd(input logic [OP_W-1:0]       op,
                                     input logic [CMD_ADDR_W-1:0] addr,
                                     input logic [CMD_DATA_W-1:0] data);
      cmd_t c;
      c.op   = op;
      c.addr = addr;
      c.data = data;
      return c;
   endfunction

endpackage

// File: rtl/iob_ethmac_seq_rom.sv
// ----------------------------------------------------------------------------
// iob_ethmac_seq_rom
// Synchronous command ROM holding the default ethmac bring-up program.
// Read latency is one clock: cmd_o reflects addr_i of the previous edge.
// Ports:
//   clk_i   in   1               system clock
//   addr_i  in   $clog2(N_CMD)   entry index (program counter)
//   cmd_o   out  cmd_t           registered command word
// Unused entries past the program hold END.
// ----------------------------------------------------------------------------
module iob_ethmac_seq_rom
   import iob_ethmac_seq_pkg::*;
#(
   parameter int N_CMD = 16
) (
   input  logic                     clk_i,
   input  logic [$clog2(N_CMD)-1:0] addr_i,
   output cmd_t                     cmd_o
);

   // MODER: loopback + full duplex, then RX/TX enable at entry 6.
   // BDs: RX BD0 gets buffer pointer then EMPTY|IRQ, TX BD0 likewise with
   // READY|IRQ. INT_MASK enables all sources, then wait for the frame.
   function automatic cmd_t rom_word(input int idx);
      case (idx)
         0:       return pack_cmd(OP_WR,   REG_MODER,            32'h0000_A080);
         1:       return pack_cmd(OP_WR,   REG_MODER,            32'h0000_A480);
         2:       return pack_cmd(OP_WR,   REG_RX_BD0 + 12'h004, 32'h0000_0080);
         3:       return pack_cmd(OP_WR,   REG_RX_BD0,           32'h0020_E000);
         4:       return pack_cmd(OP_WR,   REG_TX_BD0 + 12'h004, 32'h0000_0000);
         5:       return pack_cmd(OP_WR,   REG_TX_BD0,           32'h0020_F000);
         6:       return pack_cmd(OP_WR,   REG_MODER,            32'h0001_A4E3);
         7:       return pack_cmd(OP_WR,   REG_INT_MASK,         32'h0000_007F);
         8:       return pack_cmd(OP_WIRQ, '0,                   '0);
         9:       return pack_cmd(OP_WR,   REG_INT_SOURCE,       32'h0000_0001);
         10:      return pack_cmd(OP_POLL, REG_INT_SOURCE,       32'h0000_0004);
         11:      return pack_cmd(OP_RD,   REG_RX_BD0,           32'h0000_0000);
         default: return pack_cmd(OP_END,  '0,                   '0);
      endcase
   endfunction

   // NOTE: ROM data has no reset; its content is fixed and a reset would
   // only force the read register into flops with extra reset routing.
   always_ff @(posedge clk_i) begin
      cmd_o <= rom_word(int'(addr_i));
   end

endmodule

// File: rtl/iob_ethmac_init_seq.sv
// ----------------------------------------------------------------------------
// iob_ethmac_init_seq
// Bring-up sequencer driving the iob_ethmac native slave port. On start_i it
// executes the command program in iob_ethmac_seq_rom (writes, reads, bit
// polls and IRQ waits) and finishes in done_o, or in error_o on a timeout,
// an illegal opcode or running off the end of the ROM.
// Ports:
//   clk_i, arst_n_i     clock, asynchronous active-low reset
//   start_i             start pulse, honoured only in IDLE
//   busy_o              program running
//   done_o / error_o    sticky completion flags, cleared by start_i
//   err_pc_o            pc of the failing command
//   last_rdata_o        data of the latest RD/POLL response
//   m_valid_o, m_address_o, m_wdata_o, m_wstrb_o   iob request (wstrb=0: read)
//   m_rdata_i, m_ready_i                           iob response
//   irq_i               ethmac interrupt level
// ----------------------------------------------------------------------------
module iob_ethmac_init_seq
   import iob_ethmac_seq_pkg::*;
#(
   parameter int ADDR_W    = CMD_ADDR_W,
   parameter int DATA_W    = CMD_DATA_W,
   parameter int N_CMD     = 16,
   parameter int TIMEOUT_W = 16
) (
   input  logic                     clk_i,
   input  logic                     arst_n_i,
   input  logic                     start_i,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     error_o,
   output logic [$clog2(N_CMD)-1:0] err_pc_o,
   output logic [DATA_W-1:0]        last_rdata_o,
   output logic                     m_valid_o,
   output logic [ADDR_W-1:0]        m_address_o,
   output logic [DATA_W-1:0]        m_wdata_o,
   output logic [DATA_W/8-1:0]      m_wstrb_o,
   input  logic [DATA_W-1:0]        m_rdata_i,
   input  logic                     m_ready_i,
   input  logic                     irq_i
);

   localparam int PC_W = $clog2(N_CMD);

   state_e                state_q, state_d;
   logic [PC_W-1:0]       pc_q, pc_d;
   logic [OP_W-1:0]       op_q, op_d;
   logic [TIMEOUT_W-1:0]  tmo_q, tmo_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;
   logic [PC_W-1:0]       err_pc_q, err_pc_d;
   logic [DATA_W-1:0]     last_rdata_q, last_rdata_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   cmd_t                  rom_cmd;

   logic                  tmo_full;
   logic                  rsp_done;
   logic                  advance;
   logic                  fail;

   // The ROM is addressed with next-cycle pc so the entry is already on
   // rom_cmd during FETCH.
   iob_ethmac_seq_rom #(
      .N_CMD (N_CMD)
   ) u_rom (
      .clk_i  (clk_i),
      .addr_i (pc_d),
      .cmd_o  (rom_cmd)
   );

   assign tmo_full = &tmo_q;

   // NOTE: every signal written here gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      op_d         = op_q;
      tmo_d        = tmo_q;
      done_d       = done_q;
      error_d      = error_q;
      err_pc_d     = err_pc_q;
      last_rdata_d = last_rdata_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      m_valid_o    = 1'b0;
      m_wstrb_o    = '0;
      rsp_done     = 1'b0;
      advance      = 1'b0;
      fail         = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start_i) begin
               state_d = ST_FETCH;
               pc_d    = '0;
               done_d  = 1'b0;
               error_d = 1'b0;
            end
         end

         ST_FETCH: begin
            op_d  = rom_cmd.op;
            tmo_d = '0;
            if (pc_q == PC_W'(N_CMD - 1) && rom_cmd.op != OP_END) begin
               // Last entry must be END; the program never wraps to 0.
               fail = 1'b1;
            end else begin
               case (rom_cmd.op)
                  OP_WR, OP_RD, OP_POLL: begin
                     // Bus address/data only change here, so they stay
                     // stable across WIRQ/END entries until the next issue.
                     addr_d  = rom_cmd.addr;
                     wdata_d = rom_cmd.data;
                     state_d = ST_ISSUE;
                  end
                  OP_WIRQ: state_d = ST_WAIT_IRQ;
                  OP_END: begin
                     state_d = ST_DONE;
                     done_d  = 1'b1;
                  end
                  default: fail = 1'b1;
               endcase
            end
         end

         ST_ISSUE: begin
            m_valid_o = 1'b1;
            if (op_q == OP_WR) m_wstrb_o = '1;
            if (m_ready_i) begin
               rsp_done = 1'b1;
            end else begin
               state_d = ST_WAIT_RSP;
               // A first issue starts from a cleared counter; only a poll
               // retry (counter already running) keeps counting. Saturate
               // so WAIT_RSP still sees the expiry.
               if (tmo_q != '0 && !tmo_full) tmo_d = tmo_q + 1'b1;
            end
         end

         ST_WAIT_RSP: begin
            if (m_ready_i)     rsp_done = 1'b1;
            else if (tmo_full) fail     = 1'b1;
            else               tmo_d    = tmo_q + 1'b1;
         end

         ST_CHECK: begin
            // For POLL the data field (held in wdata_q) is the mask.
            if ((last_rdata_q & wdata_q) != '0) begin
               advance = 1'b1;
            end else if (tmo_full) begin
               fail = 1'b1;
            end else begin
               state_d = ST_ISSUE;
               tmo_d   = tmo_q + 1'b1;
            end
         end

         ST_WAIT_IRQ: begin
            if (irq_i)         advance = 1'b1;
            else if (tmo_full) fail    = 1'b1;
            else               tmo_d   = tmo_q + 1'b1;
         end

         ST_DONE, ST_ERR: state_d = ST_IDLE;

         default: state_d = ST_IDLE;
      endcase

      if (rsp_done) begin
         if (op_q != OP_WR) last_rdata_d = m_rdata_i;
         if (op_q == OP_POLL) state_d = ST_CHECK;
         else                 advance = 1'b1;
      end

      if (advance) begin
         pc_d    = pc_q + 1'b1;
         state_d = ST_FETCH;
      end

      if (fail) begin
         state_d  = ST_ERR;
         error_d  = 1'b1;
         err_pc_d = pc_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         state_q      <= ST_IDLE;
         pc_q         <= '0;
         op_q         <= OP_WR;
         tmo_q        <= '0;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
         err_pc_q     <= '0;
         last_rdata_q <= '0;
         addr_q       <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         op_q         <= op_d;
         tmo_q        <= tmo_d;
         done_q       <= done_d;
         error_q      <= error_d;
         err_pc_q     <= err_pc_d;
         last_rdata_q <= last_rdata_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign busy_o       = (state_q == ST_FETCH)    || (state_q == ST_ISSUE) ||
                         (state_q == ST_WAIT_RSP) || (state_q == ST_CHECK) ||
                         (state_q == ST_WAIT_IRQ);
   assign done_o       = done_q;
   assign error_o      = error_q;
   assign err_pc_o     = err_pc_q;
   assign last_rdata_o = last_rdata_q;
   assign m_address_o  = addr_q;
   assign m_wdata_o    = wdata_q;

endmodule
